// File: rtl/p23_spi_target.sv
// SPI mode-3 target exposing a byte register bank, plus a local valid/ready port.
// Define SPI_TARGET_IRQ_EN to pulse irq at the end of any write frame that committed data.
module p23_spi_target #(
  parameter int          ADDR_W      = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_VAL   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              valid,
  output logic              ready,
  input  logic              wstrb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              irq
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  // Bit 0 is the newest sample; the top bit is the synchronised value.
  logic [SYNC_STAGES-1:0] cen_q, sclk_q, mosi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cen_q  <= '1;
      sclk_q <= '1;
      mosi_q <= '0;
    end else begin
      cen_q  <= {cen_q[SYNC_STAGES-2:0], cen};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
  end

  logic cen_s, mosi_s, sclk_rise, sclk_fall;

  assign cen_s     = cen_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_q[SYNC_STAGES-2] & ~sclk_q[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-2] & sclk_q[SYNC_STAGES-1];

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              miso_q, miso_d;
  logic              ready_q, ready_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [7:0]        bank_q [DEPTH];

  logic [7:0]        rx_byte;
  logic              byte_done;
  logic              spi_we;
  logic              loc_go;
  logic [ADDR_W-1:0] cmd_addr;

  assign rx_byte   = {rx_q[6:0], mosi_s};
  assign byte_done = sclk_rise & (cnt_q == 3'd7);
  assign cmd_addr  = rx_byte[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    ptr_d   = ptr_q;
    miso_d  = miso_q;
    spi_we  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = 3'd0;
        miso_d = 1'b0;
        if (!cen_s) state_d = CMD;
      end
      default: begin
        if (cen_s) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          miso_d  = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_d  = rx_byte;
            cnt_d = cnt_q + 3'd1;
          end
          if (sclk_fall) begin
            miso_d = (state_q == RD) ? tx_q[7] : 1'b0;
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (byte_done) begin
            case (state_q)
              CMD: begin
                ptr_d = cmd_addr;
                if (rx_byte[7]) begin
                  state_d = WR;
                end else begin
                  state_d = RD;
                  tx_d    = bank_q[cmd_addr];
                  ptr_d   = cmd_addr + 1'b1;
                end
              end
              WR: begin
                spi_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
              end
              default: begin
                tx_d  = bank_q[ptr_q];
                ptr_d = ptr_q + 1'b1;
              end
            endcase
          end
        end
      end
    endcase
  end

  // A local write colliding with an SPI commit waits one cycle so it lands last.
  assign loc_go  = valid & ~ready_q & ~(wstrb & spi_we);
  assign ready_d = loc_go;

  always_comb begin
    rdata_d = rdata_q;
    if (loc_go && !wstrb) begin
      rdata_d = (spi_we && ptr_q == addr) ? rx_byte : bank_q[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      ptr_q   <= '0;
      miso_q  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      ptr_q   <= ptr_d;
      miso_q  <= miso_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= RESET_VAL;
    end else if (spi_we) begin
      bank_q[ptr_q] <= rx_byte;
    end else if (loc_go && wstrb) begin
      bank_q[addr] <= wdata;
    end
  end

  assign miso    = miso_q;
  assign miso_oe = ~cen_s;
  assign ready   = ready_q;
  assign rdata   = rdata_q;

`ifdef SPI_TARGET_IRQ_EN
  logic wrote_q, irq_q, frame_end;

  assign frame_end = (state_q != IDLE) & cen_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrote_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= frame_end & wrote_q;
      if (frame_end)   wrote_q <= 1'b0;
      else if (spi_we) wrote_q <= 1'b1;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
